// File: rtl/flash_req_arbiter.sv
// Round-robin arbiter sharing the SPI-flash command engine and byte FIFO between two requesters.
// Latency: gnt 1 cycle after req is sampled, start pulse 1 cycle later, done 1 cycle after CSbar rise is sampled.
// Backpressure: requests are held until gnt and are ignored while busy; a per-state watchdog aborts hung transfers.
module flash_req_arbiter #(
    parameter int TO_W    = 16,
    parameter int TIMEOUT = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        wr0,
    input  logic [23:0] addr0,
    input  logic [7:0]  nbytes0,
    output logic        gnt0,
    output logic        done0,
    output logic        err0,
    input  logic        req1,
    input  logic        wr1,
    input  logic [23:0] addr1,
    input  logic [7:0]  nbytes1,
    output logic        gnt1,
    output logic        done1,
    output logic        err1,
    output logic        flash_read,
    output logic        flash_write,
    output logic [23:0] flash_addr,
    output logic [7:0]  flash_nbytes,
    output logic        direct_fifo,
    input  logic        CSbar,
    output logic        busy,
    output logic        owner
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_START,
        S_WAIT_END,
        S_DONE
    } state_t;

    localparam logic [TO_W-1:0] WD_LAST = TO_W'(TIMEOUT - 1);

    state_t      state_q;
    logic        last_owner_q;
    logic        owner_q;
    logic        op_wr_q;
    logic        err_q;
    logic [23:0] addr_q;
    logic [7:0]  nbytes_q;
    logic        gnt0_q, gnt1_q;
    logic        done0_q, done1_q;
    logic        err0_q, err1_q;
    logic        rd_q, wrp_q;
    logic        busy_q;
    logic        dfifo_q;
    logic [TO_W-1:0] wd_q;
    logic [TO_W-1:0] wd_d;

    logic        pick_vld;
    logic        pick;
    logic        sel_wr;
    logic [23:0] sel_addr;
    logic [7:0]  sel_nbytes;

    // On a tie the port that did not own the last transaction wins.
    assign pick_vld   = req0 | req1;
    assign pick       = req1 & (~req0 | ~last_owner_q);
    assign sel_wr     = pick ? wr1 : wr0;
    assign sel_addr   = pick ? addr1 : addr0;
    assign sel_nbytes = pick ? nbytes1 : nbytes0;
    assign wd_d       = wd_q + TO_W'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            last_owner_q <= 1'b1;
            owner_q      <= 1'b0;
            op_wr_q      <= 1'b0;
            err_q        <= 1'b0;
            addr_q       <= '0;
            nbytes_q     <= '0;
            gnt0_q       <= 1'b0;
            gnt1_q       <= 1'b0;
            done0_q      <= 1'b0;
            done1_q      <= 1'b0;
            err0_q       <= 1'b0;
            err1_q       <= 1'b0;
            rd_q         <= 1'b0;
            wrp_q        <= 1'b0;
            busy_q       <= 1'b0;
            dfifo_q      <= 1'b1;
            wd_q         <= '0;
        end else begin
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            err0_q  <= 1'b0;
            err1_q  <= 1'b0;
            rd_q    <= 1'b0;
            wrp_q   <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (pick_vld) begin
                        owner_q  <= pick;
                        op_wr_q  <= sel_wr;
                        addr_q   <= sel_addr;
                        nbytes_q <= sel_nbytes;
                        err_q    <= ~sel_wr && (sel_nbytes == 8'd0);
                        gnt0_q   <= ~pick;
                        gnt1_q   <= pick;
                        busy_q   <= 1'b1;
                        dfifo_q  <= 1'b0;
                        state_q  <= S_ISSUE;
                    end
                end
                // A rejected zero-length read passes through here with its start pulse suppressed.
                S_ISSUE: begin
                    if (err_q) begin
                        state_q <= S_DONE;
                    end else begin
                        rd_q    <= ~op_wr_q;
                        wrp_q   <= op_wr_q;
                        wd_q    <= '0;
                        state_q <= S_WAIT_START;
                    end
                end
                S_WAIT_START: begin
                    if (!CSbar) begin
                        wd_q    <= '0;
                        state_q <= S_WAIT_END;
                    end else begin
                        wd_q <= wd_d;
                        if (wd_d == WD_LAST) begin
                            err_q   <= 1'b1;
                            state_q <= S_DONE;
                        end
                    end
                end
                S_WAIT_END: begin
                    if (CSbar) begin
                        state_q <= S_DONE;
                    end else begin
                        wd_q <= wd_d;
                        if (wd_d == WD_LAST) begin
                            err_q   <= 1'b1;
                            state_q <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    done0_q      <= ~owner_q;
                    done1_q      <= owner_q;
                    err0_q       <= err_q & ~owner_q;
                    err1_q       <= err_q & owner_q;
                    busy_q       <= 1'b0;
                    dfifo_q      <= 1'b1;
                    last_owner_q <= owner_q;
                    state_q      <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign gnt0         = gnt0_q;
    assign gnt1         = gnt1_q;
    assign done0        = done0_q;
    assign done1        = done1_q;
    assign err0         = err0_q;
    assign err1         = err1_q;
    assign flash_read   = rd_q;
    assign flash_write  = wrp_q;
    assign flash_addr   = addr_q;
    assign flash_nbytes = nbytes_q;
    assign direct_fifo  = dfifo_q;
    assign busy         = busy_q;
    assign owner        = owner_q;

endmodule

// File: tb/tb_flash_req_arbiter.sv
// Randomized bench for flash_req_arbiter against a transaction-level model of arbitration and timing.
module tb_flash_req_arbiter;

    localparam int TIMEOUT = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, wr0, req1, wr1;
    logic [23:0] addr0, addr1;
    logic [7:0]  nbytes0, nbytes1;
    logic        gnt0, done0, err0, gnt1, done1, err1;
    logic        flash_read, flash_write;
    logic [23:0] flash_addr;
    logic [7:0]  flash_nbytes;
    logic        direct_fifo, CSbar, busy, owner;

    int n_chk  = 0;
    int n_pass = 0;
    int m_last = 1;

    flash_req_arbiter #(.TO_W(16), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .wr0(wr0), .addr0(addr0), .nbytes0(nbytes0),
        .gnt0(gnt0), .done0(done0), .err0(err0),
        .req1(req1), .wr1(wr1), .addr1(addr1), .nbytes1(nbytes1),
        .gnt1(gnt1), .done1(done1), .err1(err1),
        .flash_read(flash_read), .flash_write(flash_write),
        .flash_addr(flash_addr), .flash_nbytes(flash_nbytes),
        .direct_fifo(direct_fifo), .CSbar(CSbar), .busy(busy), .owner(owner)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One transaction: requests pattern pat (bit0=port0, bit1=port1). The engine emulator
    // holds CSbar high for d1 cycles after the start pulse, then low for d2 cycles.
    task automatic run_txn(input int pat, input logic w0, input logic w1,
                           input logic [23:0] a0, input logic [23:0] a1,
                           input logic [7:0] n0, input logic [7:0] n1,
                           input int d1, input int d2, input bit keep, input bit noise);
        int          win, exp_off, ws, j, spur;
        bit          exp_err, zr, seen;
        logic        ew;
        logic [23:0] ea;
        logic [7:0]  en;
        req0 = pat[0]; req1 = pat[1];
        wr0 = w0; wr1 = w1; addr0 = a0; addr1 = a1; nbytes0 = n0; nbytes1 = n1;
        win = (pat == 3) ? 1 - m_last : ((pat == 2) ? 1 : 0);
        ew  = (win == 1) ? w1 : w0;
        ea  = (win == 1) ? a1 : a0;
        en  = (win == 1) ? n1 : n0;
        zr  = !ew && (en == 8'd0);
        tick();
        check("gnt0", {31'd0, gnt0}, {31'd0, win == 0});
        check("gnt1", {31'd0, gnt1}, {31'd0, win == 1});
        check("owner", {31'd0, owner}, win);
        check("flash_addr", {8'd0, flash_addr}, {8'd0, ea});
        check("flash_nbytes", {24'd0, flash_nbytes}, {24'd0, en});
        check("busy_gnt", {31'd0, busy}, 1);
        check("dfifo_gnt", {31'd0, direct_fifo}, 0);
        if (!keep) begin req0 = 1'b0; req1 = 1'b0; end
        addr0 = 24'($urandom); addr1 = 24'($urandom);
        nbytes0 = 8'($urandom); nbytes1 = 8'($urandom);
        tick();
        check("rd_pulse", {31'd0, flash_read}, {31'd0, !ew && !zr});
        check("wr_pulse", {31'd0, flash_write}, {31'd0, ew});
        ws = d1 + 1;
        if (zr) begin
            exp_off = 1; exp_err = 1;
        end else if (ws >= TIMEOUT) begin
            exp_off = TIMEOUT; exp_err = 1;
        end else if (d2 >= TIMEOUT) begin
            exp_off = ws + TIMEOUT; exp_err = 1;
        end else begin
            exp_off = ws + d2 + 1; exp_err = 0;
        end
        j = 0; seen = 0; spur = 0;
        while (!seen && j < 300) begin
            CSbar = zr ? 1'b1 : !(j >= d1 && j < d1 + d2);
            if (noise) begin
                req0 = 1'($urandom_range(0, 1));
                req1 = 1'($urandom_range(0, 1));
            end
            tick();
            j++;
            if (done0 || done1) seen = 1;
            else if (gnt0 || gnt1 || flash_read || flash_write || !busy) spur++;
        end
        CSbar = 1'b1;
        req0 = keep; req1 = keep;
        check("done_seen", {31'd0, seen}, 1);
        check("done_lat", j, exp_off);
        check("done0", {31'd0, done0}, {31'd0, win == 0});
        check("done1", {31'd0, done1}, {31'd0, win == 1});
        check("err0", {31'd0, err0}, {31'd0, exp_err && win == 0});
        check("err1", {31'd0, err1}, {31'd0, exp_err && win == 1});
        check("busy_end", {31'd0, busy}, 0);
        check("dfifo_end", {31'd0, direct_fifo}, 1);
        check("addr_hold", {8'd0, flash_addr}, {8'd0, ea});
        check("spurious", spur, 0);
        m_last = win;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, {31'd0, busy}, 0);
        check({tag, "_dfifo"}, {31'd0, direct_fifo}, 1);
        check({tag, "_owner"}, {31'd0, owner}, 0);
        check({tag, "_addr"}, {8'd0, flash_addr}, 0);
        check({tag, "_nbytes"}, {24'd0, flash_nbytes}, 0);
        check({tag, "_pulses"}, {26'd0, gnt0, gnt1, done0, done1, flash_read, flash_write}, 0);
    endtask

    initial begin
        int pat, d1, d2, r, quiet;
        rst = 1'b0; CSbar = 1'b1;
        req0 = 1'b0; req1 = 1'b0; wr0 = 1'b0; wr1 = 1'b0;
        addr0 = '0; addr1 = '0; nbytes0 = '0; nbytes1 = '0;
        repeat (3) tick();
        check_reset_outputs("reset");
        rst = 1'b1;
        tick();

        // Directed cases from the plan.
        run_txn(1, 1'b0, 1'b0, 24'h001234, 24'h0, 8'd8, 8'd0, 0, 20, 0, 0);
        run_txn(2, 1'b0, 1'b1, 24'h0, 24'hABCDEF, 8'd0, 8'd4, 2, 6, 0, 0);
        check("owner_wr", {31'd0, owner}, 1);
        run_txn(1, 1'b0, 1'b0, 24'h000100, 24'h0, 8'd16, 8'd0, 1000, 0, 0, 0);
        run_txn(1, 1'b0, 1'b0, 24'h000200, 24'h0, 8'd0, 8'd0, 0, 5, 0, 0);
        run_txn(2, 1'b0, 1'b1, 24'h0, 24'h000300, 8'd0, 8'd0, 0, 3, 0, 0);
        run_txn(1, 1'b0, 1'b0, 24'h000400, 24'h0, 8'd2, 8'd0, 1, 40, 0, 0);
        for (int i = 0; i < 4; i++)
            run_txn(3, 1'b0, 1'b1, 24'h010000 + 24'(i), 24'h020000 + 24'(i),
                    8'd1, 8'd2, 0, 10, i < 3, 0);

        // Reset in the middle of WAIT_END.
        run_txn(2, 1'b0, 1'b0, 24'h0, 24'h0, 8'd0, 8'd1, 0, 1, 0, 0);
        req1 = 1'b1; wr1 = 1'b0; nbytes1 = 8'd9; addr1 = 24'h777777;
        tick();
        req1 = 1'b0;
        tick();
        CSbar = 1'b0;
        tick(); tick();
        #2 rst = 1'b0;
        #1 check_reset_outputs("midrst");
        CSbar = 1'b1;
        tick();
        rst = 1'b1;
        quiet = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (done0 || done1 || gnt0 || gnt1) quiet++;
        end
        check("midrst_nodone", quiet, 0);
        m_last = 1;
        run_txn(3, 1'b0, 1'b0, 24'h000A00, 24'h000B00, 8'd3, 8'd3, 0, 4, 0, 0);

        // Randomized traffic.
        for (int i = 0; i < 30; i++) begin
            pat = $urandom_range(1, 3);
            d1 = $urandom_range(0, 4);
            r = $urandom_range(0, 9);
            d2 = (r == 0) ? 40 : $urandom_range(1, 12);
            if (r == 1) d1 = 1000;
            run_txn(pat, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    24'($urandom), 24'($urandom),
                    ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom),
                    ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom),
                    d1, d2, 0, 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
